radar_position_tracker: RTL and testbench
=========================================

RADAR_POSITION_TRACKER -- requirements
Module: radar_position_tracker

Interface
REQ-001 DATA_WIDTH, 32, width of every count/index port and internal counter.
REQ-002 SYS_CLK  in  1  system clock; all logic on its rising edge.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 ARP  in  1  raw azimuth reference pulse (north), asynchronous level.
REQ-005 ACP  in  1  raw azimuth change pulse, asynchronous level.
REQ-006 TRIG  in  1  raw transmit trigger, asynchronous level.
REQ-007 US_CLK  in  1  microsecond tick level; rising edge = 1 us.
REQ-008 CALIBRATED  in  1  radar_statistics calibration-complete flag.
REQ-009 ACP_CNT  in  DATA_WIDTH  ACPs per rotation, from radar_statistics.
REQ-010 CLR_ERR  in  1  single-cycle clear of sticky error flags.
REQ-011 AZIMUTH  out  DATA_WIDTH  ACP index since last ARP.
REQ-012 TRIG_IDX  out  DATA_WIDTH  TRIG count since last ACP.
REQ-013 RANGE_US  out  DATA_WIDTH  microseconds since last TRIG.
REQ-014 TRACKING  out  1  high in TRACK state.
REQ-015 SYNC_ERR  out  1  sticky: ACP count at ARP differed from ACP_CNT.
REQ-016 ACP_OVF  out  1  sticky: AZIMUTH wrapped without ARP.

Function
REQ-017 ARP, ACP, TRIG, US_CLK each SHALL pass a 2-FF synchronizer plus a history FF; event = rising edge, one SYS_CLK cycle wide.
REQ-018 Latency: an input first sampled high at SYS_CLK edge N SHALL update outputs at edge N+2 (event pulse combinational from stage 2 vs history; counters registered).
REQ-019 Input high for many cycles SHALL produce exactly one event.
REQ-020 FSM states IDLE, SYNC, TRACK; IDLE->SYNC when CALIBRATED=1; SYNC->TRACK on ARP event; any state->IDLE when CALIBRATED=0.
REQ-021 In IDLE and SYNC, AZIMUTH, TRIG_IDX, RANGE_US SHALL hold 0 and error flags SHALL not set.
REQ-022 TRACK: ARP event sets AZIMUTH to 0; ACP event without ARP increments AZIMUTH.
REQ-023 ARP and ACP in the same cycle: ARP wins, AZIMUTH=0.
REQ-024 ACP event with AZIMUTH=ACP_CNT-1 and no ARP: AZIMUTH wraps to 0, ACP_OVF set.
REQ-025 Internal rotation counter counts ACP events since last ARP; at ARP event (except SYNC->TRACK entry ARP) value != ACP_CNT sets SYNC_ERR; counter then clears (simultaneous ACP not counted in new rotation).
REQ-026 ACP event clears TRIG_IDX to 0; TRIG event increments TRIG_IDX; both same cycle gives TRIG_IDX=1.
REQ-027 TRIG event clears RANGE_US to 0; US_CLK event increments it; both same cycle gives 0.
REQ-028 TRIG_IDX and RANGE_US SHALL saturate at all-ones, no wrap.
REQ-029 ACP_CNT sampled each ARP; ACP_CNT=0 disables REQ-024 wrap and REQ-025 check.
REQ-030 CLR_ERR clears SYNC_ERR, ACP_OVF; same-cycle new error wins (flag stays 1).
REQ-031 Leaving TRACK clears TRACKING, counters to 0; error flags retained.

Reset
REQ-032 RST=1 at a SYS_CLK edge: FSM=IDLE, all outputs 0, synchronizer/history FFs 0; RST overrides all events.
REQ-033 RST asserted mid-TRACK SHALL require CALIBRATED and a fresh ARP before TRACKING=1 again.

Structure
REQ-034 FSM state encoding and DATA_WIDTH default SHALL live in the shared radar package.
REQ-035 One sub-module, radar_edge_detect (synchronizer + rising-edge pulse), instantiated four times.

Verification
REQ-036 CALIBRATED=1, ACP_CNT=5, 5 ACP per ARP -> TRACKING after first ARP, AZIMUTH 0..4 cycling, SYNC_ERR=0, ACP_OVF=0.
REQ-037 ACP_CNT=5, 6 ACPs between ARPs -> AZIMUTH wraps after 4 with ACP_OVF=1; next ARP sets SYNC_ERR=1; CLR_ERR clears both.
REQ-038 ACP and TRIG same SYS_CLK cycle with TRIG_IDX=3 -> TRIG_IDX=1; ARP+ACP same cycle at AZIMUTH=2 -> AZIMUTH=0.
REQ-039 US_CLK period 100 SYS_CLK, TRIG period 500 -> RANGE_US ramps 0..4 then 0; ARP high 40 cycles -> single event; output change 2 edges after sample.
REQ-040 CALIBRATED dropped mid-TRACK -> IDLE, counters 0 next edge; RST mid-TRACK -> all outputs 0; restore -> TRACKING only after next ARP.

Source files
------------

// File: rtl/radar_position_tracker_pkg.sv
// Shared definitions for the radar position tracker: default counter width
// and the tracking state machine encoding.
package radar_position_tracker_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_TRACK = 2'd2
  } track_state_e;

endpackage

// File: rtl/radar_position_tracker_if.sv
// Signal bundle between the radar front end / statistics block (master)
// and the position tracker (slave).
interface radar_position_tracker_if
  import radar_position_tracker_pkg::*;
#(
  parameter int DW = DATA_WIDTH
);

  logic          arp;
  logic          acp;
  logic          trig;
  logic          us_clk;
  logic          calibrated;
  logic [DW-1:0] acp_cnt;
  logic          clr_err;

  logic [DW-1:0] azimuth;
  logic [DW-1:0] trig_idx;
  logic [DW-1:0] range_us;
  logic          tracking;
  logic          sync_err;
  logic          acp_ovf;

  modport master (
    output arp, acp, trig, us_clk, calibrated, acp_cnt, clr_err,
    input  azimuth, trig_idx, range_us, tracking, sync_err, acp_ovf
  );

  modport slave (
    input  arp, acp, trig, us_clk, calibrated, acp_cnt, clr_err,
    output azimuth, trig_idx, range_us, tracking, sync_err, acp_ovf
  );

endinterface

// File: rtl/radar_edge_detect.sv
// Two-flop synchronizer for an asynchronous level followed by a history
// flop; pulse is high for exactly one clock after each rising edge.
module radar_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic sync1_r;
  logic sync2_r;
  logic hist_r;

  // Synchronizer chain plus history stage, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      hist_r  <= 1'b0;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
      hist_r  <= sync2_r;
    end
  end

  // Rising edge seen at the synchronized stage
  assign pulse = sync2_r & ~hist_r;

endmodule

// File: rtl/radar_position_tracker.sv
// Radar position tracker: locks onto the north reference (ARP), then keeps
// azimuth index, trigger index within the current ACP and range in
// microseconds since the last trigger, with sticky sync/overflow errors.
module radar_position_tracker
  import radar_position_tracker_pkg::*;
#(
  parameter int DW = DATA_WIDTH
) (
  input logic                     sys_clk,
  input logic                     rst,
  radar_position_tracker_if.slave bus
);

  localparam logic [DW-1:0] ZERO = {DW{1'b0}};
  localparam logic [DW-1:0] ONE  = {{(DW-1){1'b0}}, 1'b1};

  track_state_e  state_r;
  track_state_e  state_next_s;

  logic          arp_ev_s;
  logic          acp_ev_s;
  logic          trig_ev_s;
  logic          us_ev_s;

  logic [DW-1:0] az_r;
  logic [DW-1:0] az_next_s;
  logic [DW-1:0] trig_idx_r;
  logic [DW-1:0] trig_idx_next_s;
  logic [DW-1:0] range_r;
  logic [DW-1:0] range_next_s;
  logic [DW-1:0] rot_r;
  logic [DW-1:0] rot_next_s;
  logic [DW-1:0] closing_s;
  logic [DW-1:0] acp_cnt_r;

  logic          stay_track_s;
  logic          set_sync_s;
  logic          set_ovf_s;
  logic          tracking_r;
  logic          sync_err_r;
  logic          acp_ovf_r;

  radar_edge_detect u_arp_edge  (.clk(sys_clk), .rst(rst), .din(bus.arp),    .pulse(arp_ev_s));
  radar_edge_detect u_acp_edge  (.clk(sys_clk), .rst(rst), .din(bus.acp),    .pulse(acp_ev_s));
  radar_edge_detect u_trig_edge (.clk(sys_clk), .rst(rst), .din(bus.trig),   .pulse(trig_ev_s));
  radar_edge_detect u_us_edge   (.clk(sys_clk), .rst(rst), .din(bus.us_clk), .pulse(us_ev_s));

  // Next state: calibration loss always returns to IDLE
  always_comb begin
    state_next_s = state_r;
    if (!bus.calibrated) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:  state_next_s = ST_SYNC;
        ST_SYNC: begin
          if (arp_ev_s) state_next_s = ST_TRACK;
          else          state_next_s = ST_SYNC;
        end
        ST_TRACK: state_next_s = ST_TRACK;
        default:  state_next_s = ST_IDLE;
      endcase
    end
  end

  // Counter updates; only a cycle that starts and stays in TRACK counts,
  // every other cycle forces the counters back to zero
  always_comb begin
    stay_track_s    = (state_r == ST_TRACK) && (state_next_s == ST_TRACK);
    az_next_s       = ZERO;
    rot_next_s      = ZERO;
    trig_idx_next_s = ZERO;
    range_next_s    = ZERO;
    set_sync_s      = 1'b0;
    set_ovf_s       = 1'b0;
    // An ACP coinciding with the ARP closes the old rotation
    closing_s       = acp_ev_s ? (rot_r + ONE) : rot_r;
    if (stay_track_s) begin
      if (arp_ev_s) begin
        az_next_s  = ZERO;
        rot_next_s = ZERO;
        set_sync_s = (acp_cnt_r != ZERO) && (closing_s != acp_cnt_r);
      end else if (acp_ev_s) begin
        rot_next_s = (&rot_r) ? rot_r : (rot_r + ONE);
        if ((acp_cnt_r != ZERO) && (az_r == (acp_cnt_r - ONE))) begin
          az_next_s = ZERO;
          set_ovf_s = 1'b1;
        end else begin
          az_next_s = az_r + ONE;
        end
      end else begin
        az_next_s  = az_r;
        rot_next_s = rot_r;
      end

      if (acp_ev_s) begin
        trig_idx_next_s = trig_ev_s ? ONE : ZERO;
      end else if (trig_ev_s && !(&trig_idx_r)) begin
        trig_idx_next_s = trig_idx_r + ONE;
      end else begin
        trig_idx_next_s = trig_idx_r;
      end

      if (trig_ev_s) begin
        range_next_s = ZERO;
      end else if (us_ev_s && !(&range_r)) begin
        range_next_s = range_r + ONE;
      end else begin
        range_next_s = range_r;
      end
    end else begin
      az_next_s = ZERO;
    end
  end

  // State, counters, latched rotation length and sticky error flags
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      az_r       <= ZERO;
      rot_r      <= ZERO;
      trig_idx_r <= ZERO;
      range_r    <= ZERO;
      acp_cnt_r  <= ZERO;
      tracking_r <= 1'b0;
      sync_err_r <= 1'b0;
      acp_ovf_r  <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      az_r       <= az_next_s;
      rot_r      <= rot_next_s;
      trig_idx_r <= trig_idx_next_s;
      range_r    <= range_next_s;
      tracking_r <= (state_next_s == ST_TRACK);

      if (arp_ev_s) acp_cnt_r <= bus.acp_cnt;
      else          acp_cnt_r <= acp_cnt_r;

      // A new error in the same cycle as a clear keeps the flag set
      if (set_sync_s)       sync_err_r <= 1'b1;
      else if (bus.clr_err) sync_err_r <= 1'b0;
      else                  sync_err_r <= sync_err_r;

      if (set_ovf_s)        acp_ovf_r <= 1'b1;
      else if (bus.clr_err) acp_ovf_r <= 1'b0;
      else                  acp_ovf_r <= acp_ovf_r;
    end
  end

  assign bus.azimuth  = az_r;
  assign bus.trig_idx = trig_idx_r;
  assign bus.range_us = range_r;
  assign bus.tracking = tracking_r;
  assign bus.sync_err = sync_err_r;
  assign bus.acp_ovf  = acp_ovf_r;

endmodule

// File: tb/tb_radar_position_tracker.sv
// Bench for radar_position_tracker: directed scenarios plus a randomized
// run, all compared against a cycle-level reference model of the tracker.
module tb_radar_position_tracker;

  localparam longint MAXV = 64'hFFFF_FFFF;

  logic clk;
  logic rst;
  int   vec;
  int   miss;

  radar_position_tracker_if #(.DW(32)) bus ();

  radar_position_tracker dut (
    .sys_clk(clk),
    .rst    (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state (0 idle, 1 sync, 2 track)
  int     m_state;
  longint m_az, m_ti, m_rng, m_rot, m_cnt;
  bit     m_trk, m_se, m_ov;
  bit     d1 [4];
  bit     d2 [4];
  bit     d3 [4];

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_edge();
    bit inp [4];
    bit ev  [4];
    bit arp, acp, trg, us, se_set, ov_set;
    int nxt;
    inp = '{bus.arp, bus.acp, bus.trig, bus.us_clk};
    // A level first sampled at edge k becomes an event at edge k+2
    for (int i = 0; i < 4; i++) ev[i] = d2[i] && !d3[i];
    if (rst) begin
      m_state = 0; m_az = 0; m_ti = 0; m_rng = 0; m_rot = 0; m_cnt = 0;
      m_trk = 0; m_se = 0; m_ov = 0;
      for (int i = 0; i < 4; i++) begin d1[i] = 0; d2[i] = 0; d3[i] = 0; end
      return;
    end
    d3 = d2; d2 = d1; d1 = inp;
    arp = ev[0]; acp = ev[1]; trg = ev[2]; us = ev[3];
    if (!bus.calibrated)  nxt = 0;
    else if (m_state == 0) nxt = 1;
    else if (m_state == 1) nxt = arp ? 2 : 1;
    else                   nxt = 2;
    se_set = 0; ov_set = 0;
    if (m_state == 2 && nxt == 2) begin
      if (arp) begin
        if (m_cnt != 0 && (m_rot + (acp ? 1 : 0)) != m_cnt) se_set = 1;
        m_az = 0; m_rot = 0;
      end else if (acp) begin
        if (m_rot < MAXV) m_rot = m_rot + 1;
        if (m_cnt != 0 && m_az == m_cnt - 1) begin m_az = 0; ov_set = 1; end
        else m_az = (m_az + 1) & MAXV;
      end
      if (acp)                    m_ti = trg ? 1 : 0;
      else if (trg && m_ti < MAXV) m_ti = m_ti + 1;
      if (trg)                    m_rng = 0;
      else if (us && m_rng < MAXV) m_rng = m_rng + 1;
    end else begin
      m_az = 0; m_ti = 0; m_rng = 0; m_rot = 0;
    end
    if (arp) m_cnt = bus.acp_cnt;
    if (se_set)            m_se = 1;
    else if (bus.clr_err)  m_se = 0;
    if (ov_set)            m_ov = 1;
    else if (bus.clr_err)  m_ov = 0;
    m_trk   = (nxt == 2);
    m_state = nxt;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic pulse(input bit a, input bit c, input bit t, input bit u,
                       input int hi, input int lo);
    bus.arp = a; bus.acp = c; bus.trig = t; bus.us_clk = u;
    repeat (hi) tick();
    bus.arp = 0; bus.acp = 0; bus.trig = 0; bus.us_clk = 0;
    repeat (lo) tick();
  endtask

  function automatic logic [98:0] dut_vec();
    return {bus.tracking, bus.sync_err, bus.acp_ovf, bus.azimuth, bus.trig_idx, bus.range_us};
  endfunction

  function automatic logic [98:0] model_vec();
    logic [31:0] a, t, r;
    a = m_az[31:0]; t = m_ti[31:0]; r = m_rng[31:0];
    return {m_trk, m_se, m_ov, a, t, r};
  endfunction

  task automatic test_reset();
    logic [98:0] zero_v;
    zero_v = '0;
    rst = 1; bus.calibrated = 1; bus.arp = 1; bus.acp = 1;
    tick(); tick(); tick();
    vec++;
    if (dut_vec() !== zero_v) begin
      miss++; $display("FAIL reset_outputs got=%h exp=%h", dut_vec(), zero_v);
    end
    bus.arp = 0; bus.acp = 0; bus.calibrated = 0;
    tick();
    rst = 0;
    tick();
    vec++;
    if (dut_vec() !== model_vec()) begin
      miss++; $display("FAIL reset_model got=%h exp=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_rotation();
    bus.calibrated = 1; bus.acp_cnt = 32'd5;
    tick();
    vec++;
    if (bus.tracking !== 1'b0) begin
      miss++; $display("FAIL sync_not_tracking got=%b exp=0", bus.tracking);
    end
    pulse(1, 0, 0, 0, 3, 4);
    vec++;
    if (bus.tracking !== 1'b1 || bus.azimuth !== 32'd0) begin
      miss++; $display("FAIL first_arp got trk=%b az=%0d exp trk=1 az=0", bus.tracking, bus.azimuth);
    end
    for (int r = 0; r < 2; r++) begin
      for (int k = 1; k <= 4; k++) begin
        pulse(0, 1, 0, 0, 2, 3);
        vec++;
        if (bus.azimuth !== k[31:0] || dut_vec() !== model_vec()) begin
          miss++; $display("FAIL rotation_az got=%0d exp=%0d", bus.azimuth, k);
        end
      end
      pulse(1, 1, 0, 0, 2, 3);
      vec++;
      if (bus.azimuth !== 32'd0 || bus.sync_err !== 1'b0 || bus.acp_ovf !== 1'b0) begin
        miss++; $display("FAIL rotation_north got az=%0d se=%b ov=%b exp 0/0/0",
                         bus.azimuth, bus.sync_err, bus.acp_ovf);
      end
    end
  endtask

  task automatic test_overflow();
    for (int k = 1; k <= 5; k++) begin
      pulse(0, 1, 0, 0, 2, 3);
      vec++;
      if (bus.azimuth !== ((k == 5) ? 32'd0 : k[31:0]) || bus.acp_ovf !== (k == 5)) begin
        miss++; $display("FAIL ovf_az got az=%0d ov=%b step=%0d", bus.azimuth, bus.acp_ovf, k);
      end
    end
    pulse(1, 1, 0, 0, 2, 3);
    vec++;
    if (bus.sync_err !== 1'b1 || bus.acp_ovf !== 1'b1) begin
      miss++; $display("FAIL ovf_sync got se=%b ov=%b exp 1/1", bus.sync_err, bus.acp_ovf);
    end
    bus.clr_err = 1; tick(); bus.clr_err = 0; tick();
    vec++;
    if (bus.sync_err !== 1'b0 || bus.acp_ovf !== 1'b0) begin
      miss++; $display("FAIL clr_err got se=%b ov=%b exp 0/0", bus.sync_err, bus.acp_ovf);
    end
  endtask

  task automatic test_same_cycle();
    pulse(1, 0, 0, 0, 2, 3);
    bus.clr_err = 1; tick(); bus.clr_err = 0; tick();
    vec++;
    if (bus.sync_err !== 1'b0 || bus.azimuth !== 32'd0) begin
      miss++; $display("FAIL same_prep got se=%b az=%0d exp 0/0", bus.sync_err, bus.azimuth);
    end
    repeat (3) pulse(0, 0, 1, 0, 2, 3);
    vec++;
    if (bus.trig_idx !== 32'd3) begin
      miss++; $display("FAIL trig_count got=%0d exp=3", bus.trig_idx);
    end
    pulse(0, 1, 1, 0, 2, 3);
    vec++;
    if (bus.trig_idx !== 32'd1 || bus.azimuth !== 32'd1) begin
      miss++; $display("FAIL acp_trig_same got ti=%0d az=%0d exp 1/1", bus.trig_idx, bus.azimuth);
    end
    pulse(0, 1, 0, 0, 2, 3);
    // ARP+ACP at azimuth 2 with a clear landing on the same edge as the error
    bus.arp = 1; bus.acp = 1;
    tick(); tick();
    bus.clr_err = 1;
    tick();
    bus.clr_err = 0; bus.arp = 0; bus.acp = 0;
    repeat (3) tick();
    vec++;
    if (bus.azimuth !== 32'd0 || bus.sync_err !== 1'b1 || dut_vec() !== model_vec()) begin
      miss++; $display("FAIL arp_acp_same got az=%0d se=%b exp 0/1", bus.azimuth, bus.sync_err);
    end
    bus.clr_err = 1; tick(); bus.clr_err = 0; tick();
  endtask

  task automatic test_range();
    for (int cyc = 0; cyc < 1100; cyc++) begin
      bus.trig   = ((cyc % 500) < 5);
      bus.us_clk = ((cyc % 100) < 50);
      tick();
      vec++;
      if (dut_vec() !== model_vec()) begin
        miss++; $display("FAIL range_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec());
      end
      if (cyc == 450 || cyc == 960 || cyc == 505) begin
        vec++;
        if (bus.range_us !== ((cyc == 505) ? 32'd0 : 32'd4)) begin
          miss++; $display("FAIL range_ramp cyc=%0d got=%0d", cyc, bus.range_us);
        end
      end
    end
    bus.trig = 0; bus.us_clk = 0;
    repeat (4) tick();
    // Long ARP: one event only, so an ACP during it still counts
    bus.arp = 1;
    repeat (10) tick();
    bus.acp = 1; tick(); tick(); bus.acp = 0;
    repeat (28) tick();
    bus.arp = 0;
    repeat (4) tick();
    vec++;
    if (bus.azimuth !== 32'd1) begin
      miss++; $display("FAIL long_arp got az=%0d exp=1", bus.azimuth);
    end
    bus.acp = 1;
    tick();
    tick();
    vec++;
    if (bus.azimuth !== 32'd1) begin
      miss++; $display("FAIL latency_early got az=%0d exp=1", bus.azimuth);
    end
    tick();
    vec++;
    if (bus.azimuth !== 32'd2) begin
      miss++; $display("FAIL latency_n2 got az=%0d exp=2", bus.azimuth);
    end
    bus.acp = 0;
    repeat (3) tick();
  endtask

  task automatic test_calib_reset();
    logic [98:0] zero_v;
    zero_v = '0;
    pulse(0, 0, 1, 0, 2, 3);
    bus.calibrated = 0;
    tick();
    vec++;
    if (bus.tracking !== 1'b0 || bus.azimuth !== 32'd0 || bus.trig_idx !== 32'd0 ||
        bus.range_us !== 32'd0 || dut_vec() !== model_vec()) begin
      miss++; $display("FAIL calib_drop got=%h exp=%h", dut_vec(), model_vec());
    end
    bus.calibrated = 1;
    repeat (10) tick();
    vec++;
    if (bus.tracking !== 1'b0) begin
      miss++; $display("FAIL calib_wait got trk=%b exp=0", bus.tracking);
    end
    pulse(1, 0, 0, 0, 2, 3);
    pulse(0, 1, 0, 0, 2, 3);
    vec++;
    if (bus.tracking !== 1'b1 || bus.azimuth !== 32'd1) begin
      miss++; $display("FAIL calib_relock got trk=%b az=%0d exp 1/1", bus.tracking, bus.azimuth);
    end
    rst = 1; tick(); rst = 0;
    vec++;
    if (dut_vec() !== zero_v) begin
      miss++; $display("FAIL mid_reset got=%h exp=0", dut_vec());
    end
    repeat (10) tick();
    vec++;
    if (bus.tracking !== 1'b0) begin
      miss++; $display("FAIL reset_wait got trk=%b exp=0", bus.tracking);
    end
    pulse(1, 0, 0, 0, 2, 3);
    vec++;
    if (bus.tracking !== 1'b1 || dut_vec() !== model_vec()) begin
      miss++; $display("FAIL reset_relock got=%h exp=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_random();
    logic [31:0] cnts [5];
    cnts = '{32'd0, 32'd3, 32'd5, 32'd7, 32'd2};
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(0, 29) == 0) bus.arp    = ~bus.arp;
      if ($urandom_range(0, 4)  == 0) bus.acp    = ~bus.acp;
      if ($urandom_range(0, 2)  == 0) bus.trig   = ~bus.trig;
      if ($urandom_range(0, 1)  == 0) bus.us_clk = ~bus.us_clk;
      if (bus.calibrated) bus.calibrated = ($urandom_range(0, 599) != 0);
      else                bus.calibrated = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 499) == 0) bus.acp_cnt = cnts[$urandom_range(0, 4)];
      bus.clr_err = ($urandom_range(0, 29) == 0);
      rst = ($urandom_range(0, 1999) == 0);
      tick();
      vec++;
      if (dut_vec() !== model_vec()) begin
        miss++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec());
      end
    end
    rst = 0; bus.clr_err = 0;
  endtask

  initial begin
    vec = 0; miss = 0;
    rst = 1;
    bus.arp = 0; bus.acp = 0; bus.trig = 0; bus.us_clk = 0;
    bus.calibrated = 0; bus.acp_cnt = 32'd0; bus.clr_err = 0;
    test_reset();
    test_rotation();
    test_overflow();
    test_same_cycle();
    test_range();
    test_calib_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
